// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep controller driving the DDS `fin` word.
// Single, sawtooth-repeat and triangle-repeat sweeps with a programmable dwell per value.
module dds_sweep_ctrl #(
  parameter int FW = 24,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic [1:0]    mode,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  output logic [FW-1:0] fin,
  output logic          busy,
  output logic          done,
  output logic          step_tick
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD_END} state_t;
  typedef enum logic [1:0] {M_SINGLE = 2'b00, M_SAW = 2'b01, M_TRI = 2'b10} mode_t;
  typedef struct packed {
    logic          hit;
    logic [FW-1:0] val;
  } adv_t;

  state_t        state, state_d;
  mode_t         s_mode;
  logic [FW-1:0] s_start, s_stop, s_step;
  logic [DW-1:0] s_last, cnt, cnt_d;
  logic          fwd, fwd_d;
  logic [FW-1:0] fin_d;
  logic          busy_d, done_d, tick_d;
  logic          accept, orig_up, leg_up;
  logic [FW-1:0] leg_tgt, rev_tgt;
  adv_t          adv_run, adv_rev;

  // One step toward tgt, clamped so fin never overshoots or wraps.
  function automatic adv_t advance(input logic [FW-1:0] cur, input logic [FW-1:0] tgt,
                                   input logic [FW-1:0] step, input logic up);
    logic [FW:0] sum;
    adv_t        r;
    sum = {1'b0, cur} + {1'b0, step};
    if (step == '0)
      r.hit = 1'b1;
    else if (up)
      r.hit = sum[FW] || (sum[FW-1:0] >= tgt);
    else
      r.hit = (cur < step) || ((cur - step) <= tgt);
    r.val = r.hit ? tgt : (up ? sum[FW-1:0] : cur - step);
    return r;
  endfunction

  assign accept = (state == IDLE) && start && !stop;

  // fwd marks the leg heading toward s_stop; triangle mode toggles it at each endpoint.
  always_comb begin
    orig_up = (s_stop >= s_start);
    leg_up  = fwd ? orig_up : !orig_up;
    leg_tgt = fwd ? s_stop : s_start;
    rev_tgt = fwd ? s_start : s_stop;
    adv_run = advance(fin, leg_tgt, s_step, leg_up);
    adv_rev = advance(fin, rev_tgt, s_step, !leg_up);
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d = state;
    fin_d   = fin;
    busy_d  = busy;
    done_d  = 1'b0;
    cnt_d   = cnt;
    fwd_d   = fwd;
    tick_d  = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          fin_d   = f_start;
          cnt_d   = '0;
          busy_d  = 1'b1;
          fwd_d   = 1'b1;
          state_d = (f_start == f_stop) ? HOLD_END : RUN;
        end
      end
      RUN: begin
        if (cnt == s_last) begin
          cnt_d = '0;
          fin_d = adv_run.val;
          if (adv_run.hit) state_d = HOLD_END;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      HOLD_END: begin
        if (cnt == s_last) begin
          cnt_d  = '0;
          done_d = 1'b1;
          unique case (s_mode)
            M_SAW: begin
              fin_d   = s_start;
              fwd_d   = 1'b1;
              state_d = (s_start == s_stop) ? HOLD_END : RUN;
            end
            M_TRI: begin
              fwd_d   = !fwd;
              fin_d   = adv_rev.val;
              state_d = adv_rev.hit ? HOLD_END : RUN;
            end
            default: begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          endcase
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop) begin
      state_d = IDLE;
      fin_d   = fin;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      cnt_d   = '0;
    end

    // The load on an accepted start is the sweep's origin, not a step.
    tick_d = (state != IDLE) && (fin_d != fin);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fin       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      step_tick <= 1'b0;
      cnt       <= '0;
      fwd       <= 1'b1;
      s_mode    <= M_SINGLE;
      s_start   <= '0;
      s_stop    <= '0;
      s_step    <= '0;
      s_last    <= '0;
    end else begin
      state     <= state_d;
      fin       <= fin_d;
      busy      <= busy_d;
      done      <= done_d;
      step_tick <= tick_d;
      cnt       <= cnt_d;
      fwd       <= fwd_d;
      if (accept) begin
        s_mode  <= (mode == 2'b11) ? M_SINGLE : mode_t'(mode);
        s_start <= f_start;
        s_stop  <= f_stop;
        s_step  <= f_step;
        s_last  <= (dwell == '0) ? '0 : dwell - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: table of sweeps expanded into a per-cycle
// expected-output queue, plus hand-written abort and reset sequences.
module tb_dds_sweep_ctrl;
  localparam int FW = 24;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [1:0]    mode = '0;
  logic [FW-1:0] f_start = '0, f_stop = '0, f_step = '0;
  logic [DW-1:0] dwell = '0;
  logic [FW-1:0] fin;
  logic          busy, done, step_tick;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .fin(fin), .busy(busy), .done(done), .step_tick(step_tick)
  );

  // vals: every distinct value held, in order; endm bit i: leaving vals[i] pulses done.
  // stop_at: index of the output cycle produced by the edge where stop is asserted (-1 = none).
  typedef struct packed {
    logic [7:0][FW-1:0] vals;
    logic [7:0]         endm;
    logic [1:0]         mode;
    logic [FW-1:0]      fs, fe, st;
    logic [DW-1:0]      dw;
    int                 n;
    int                 stop_at;
  } vec_t;

  typedef struct packed {
    logic [FW-1:0] fin;
    logic          busy, done, tick, tick_dc;
  } exp_t;

  vec_t          vecs[12];
  int            nvec = 0;
  exp_t          sb[$];
  int            n_cmp = 0, n_bad = 0;
  logic [FW-1:0] exp_last = '0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] m, input int fs, input int fe, input int st,
                     input int dw, input int stop_at, input logic [7:0] endm, input int n,
                     input int v0, input int v1 = 0, input int v2 = 0, input int v3 = 0,
                     input int v4 = 0, input int v5 = 0, input int v6 = 0);
    vec_t v;
    v = '0;
    v.mode = m; v.fs = FW'(fs); v.fe = FW'(fe); v.st = FW'(st); v.dw = DW'(dw);
    v.stop_at = stop_at; v.endm = endm; v.n = n;
    v.vals[0] = FW'(v0); v.vals[1] = FW'(v1); v.vals[2] = FW'(v2); v.vals[3] = FW'(v3);
    v.vals[4] = FW'(v4); v.vals[5] = FW'(v5); v.vals[6] = FW'(v6);
    vecs[nvec] = v;
    nvec++;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int   d, total;
    exp_t e;
    d = (v.dw == '0) ? 1 : int'(v.dw);
    for (int i = 0; i < v.n; i++) begin
      for (int k = 0; k < d; k++) begin
        e.fin     = v.vals[i];
        e.busy    = 1'b1;
        e.done    = (k == 0 && i > 0) ? v.endm[i-1] : 1'b0;
        e.tick    = (k == 0 && i > 0) && (v.vals[i] != v.vals[i-1]);
        e.tick_dc = (k == 0 && i == 0);
        sb.push_back(e);
      end
    end
    if (v.stop_at < 0) begin
      sb.push_back('{fin: v.vals[v.n-1], busy: 1'b0, done: 1'b1, tick: 1'b0, tick_dc: 1'b0});
    end else begin
      while (sb.size() > v.stop_at) void'(sb.pop_back());
      sb.push_back('{fin: sb[$].fin, busy: 1'b0, done: 1'b0, tick: 1'b0, tick_dc: 1'b0});
    end
    sb.push_back('{fin: sb[$].fin, busy: 1'b0, done: 1'b0, tick: 1'b0, tick_dc: 1'b0});
    exp_last = sb[$].fin;

    total = sb.size();
    for (int j = 0; j < total; j++) begin
      if (j == 0) begin
        mode = v.mode; f_start = v.fs; f_stop = v.fe; f_step = v.st; dwell = v.dw;
        start = 1'b1;
      end else begin
        // Scrambled inputs mid-sweep must be ignored; a start pulse while busy too.
        mode = 2'($urandom); f_start = FW'($urandom); f_stop = FW'($urandom);
        f_step = FW'($urandom); dwell = DW'($urandom_range(0, 7));
        start = (j == 1);
      end
      stop = (v.stop_at >= 0) && (j == v.stop_at);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("v%0d c%0d fin", id, j), fin, e.fin);
      check($sformatf("v%0d c%0d busy", id, j), FW'(busy), FW'(e.busy));
      check($sformatf("v%0d c%0d done", id, j), FW'(done), FW'(e.done));
      if (!e.tick_dc)
        check($sformatf("v%0d c%0d step_tick", id, j), FW'(step_tick), FW'(e.tick));
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    add(2'd0, 1000, 1010, 4, 3, -1, 8'h08, 4, 1000, 1004, 1008, 1010);
    add(2'd0, 20, 5, 8, 1, -1, 8'h04, 3, 20, 12, 5);
    add(2'd0, 'hFFFFF0, 'hFFFFFF, 'h20, 2, -1, 8'h02, 2, 'hFFFFF0, 'hFFFFFF);
    add(2'd2, 0, 6, 3, 2, 14, 8'h54, 7, 0, 3, 6, 3, 0, 3, 6);
    add(2'd1, 1000, 1010, 4, 3, 18, 8'h08, 6, 1000, 1004, 1008, 1010, 1000, 1004);
    add(2'd0, 1000, 1010, 4, 3, 5, 8'h08, 4, 1000, 1004, 1008, 1010);
    add(2'd0, 10, 13, 1, 0, -1, 8'h08, 4, 10, 11, 12, 13);
    add(2'd0, 100, 50, 0, 2, -1, 8'h02, 2, 100, 50);
    add(2'd0, 77, 77, 5, 4, -1, 8'h01, 1, 77);
    add(2'd2, 9, 1, 4, 1, 6, 8'h14, 6, 9, 5, 1, 5, 9, 5);
    add(2'd3, 5, 1, 2, 1, -1, 8'h04, 3, 5, 3, 1);

    #1 rst_n = 1'b0;
    #1;
    check("reset fin", fin, '0);
    check("reset busy", FW'(busy), '0);
    check("reset done", FW'(done), '0);
    check("reset step_tick", FW'(step_tick), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < nvec; i++) run_vec(vecs[i], i);

    // start and stop together from IDLE: nothing happens.
    mode = 2'd0; f_start = 24'h123456; f_stop = 24'h123460; f_step = 24'd1; dwell = 24'd1;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start+stop fin", fin, exp_last);
    check("start+stop busy", FW'(busy), '0);
    check("start+stop done", FW'(done), '0);
    @(negedge clk);
    check("start+stop idle fin", fin, exp_last);
    check("start+stop idle busy", FW'(busy), '0);

    // Asynchronous reset in the middle of a sawtooth sweep.
    mode = 2'd1; f_start = 24'd500; f_stop = 24'd600; f_step = 24'd10; dwell = 24'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst seq fin0", fin, 24'd500);
    check("rst seq busy", FW'(busy), 24'd1);
    repeat (3) @(negedge clk);
    check("rst seq fin1", fin, 24'd510);
    #2 rst_n = 1'b0;
    #1;
    check("async rst fin", fin, '0);
    check("async rst busy", FW'(busy), '0);
    check("async rst done", FW'(done), '0);
    check("async rst step_tick", FW'(step_tick), '0);
    @(negedge clk);
    check("held rst fin", fin, '0);
    check("held rst done", FW'(done), '0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Linear frequency-sweep controller that generates the 24-bit `fin` frequency word driving the DDS sine stage. It sits directly upstream of the phase accumulator. On a start command it steps the frequency from a start value to a stop value in fixed increments, holding each value for a programmable dwell. It supports single-shot, sawtooth-repeat and triangle-repeat modes.

## Interface
- `FW`, 24: frequency word width; matches the DDS `fin` input.
- `DW`, 24: dwell counter width, in clock cycles.

- `clk`  in  1  system clock, same clock as the DDS stage.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  level sampled each rising edge; begins a sweep when idle.
- `stop`  in  1  aborts the sweep; has priority over `start`.
- `mode`  in  2  00 single, 01 sawtooth repeat, 10 triangle repeat, 11 treated as 00.
- `f_start`  in  FW  first frequency word.
- `f_stop`  in  FW  final frequency word.
- `f_step`  in  FW  increment magnitude, unsigned.
- `dwell`  in  DW  cycles each value is held; 0 is treated as 1.
- `fin`  out  FW  registered frequency word to the DDS.
- `busy`  out  1  high while a sweep is active.
- `done`  out  1  one-cycle pulse at the end of each leg.
- `step_tick`  out  1  one-cycle pulse whenever `fin` changes value during a sweep.

## Operation
- **Reset values.** All outputs are 0 and the FSM is in IDLE.
- **Shadow registers.** `f_start`, `f_stop`, `f_step`, `dwell` and `mode` are latched on the accepted start. Later input changes have no effect until the next start.
- **FSM states:** IDLE, RUN, HOLD_END.
- **IDLE.**
  - `fin` holds its last value.
  - `start=1` and `stop=0` → latch the shadow registers, `fin<=f_start`, dwell count cleared, `busy<=1`, go to RUN.
  - Direction is up when `f_stop >= f_start`, otherwise down.
- **RUN.** The dwell counter runs 0..D-1, where D = max(`dwell`,1). At count D-1 the counter clears and `fin` advances:
  - Up: next = `fin + f_step`, computed at FW+1 bits. If next >= target or the add carries out, `fin<=target` and go to HOLD_END.
  - Down: if `fin < f_step` or `fin - f_step <= target`, `fin<=target` and go to HOLD_END; otherwise `fin<=fin-f_step`.
  - `step_tick` pulses on every edge where `fin` changes value.
- **Special cases.**
  - `f_start == f_stop`: go straight to HOLD_END on the accepted start.
  - `f_step == 0`: clamp to target on the first advance.
- **HOLD_END.** `fin` holds the target for D cycles. At count D-1, `done` pulses for one cycle and the next action depends on mode:
  - mode 00: go to IDLE, `busy<=0`, `fin` keeps the target.
  - mode 01: `fin<=f_start`, original direction, go to RUN.
  - mode 10: swap the target between `f_stop` and `f_start`, reverse direction, advance one step toward the new target, go to RUN. Each endpoint is held once, not doubled.
- **`stop`.** From any state, go to IDLE on the next edge. `busy<=0`, `fin` frozen at its current value, no `done` pulse, dwell count cleared.
- **`start` while busy** is ignored.
- **Reset mid-sweep** returns to the reset values immediately, with no `done` pulse.

## Timing
- Zero-latency registered outputs: on an accepted start at edge N, `fin=f_start` and `busy=1` are visible after edge N.
- Value vi (i = 0..k, with vk = target) is driven from edge N+i·D to edge N+(i+1)·D.
- Single mode: at edge N+(k+1)·D, `busy` falls and `done=1` for exactly one cycle; `fin` stays vk.
- `step_tick` and `done` are registered and aligned to the edge where `fin` updates.
- Sawtooth mode: `fin` wraps from target back to `f_start` at the same edge that `done` pulses.
- All arithmetic is unsigned. No wrap-around of `fin` is permitted; every sweep is clamped at its target.

## Test plan
- **Single up sweep.** `f_start=1000`, `f_stop=1010`, `f_step=4`, `dwell=3`, mode 00 → `fin` = 1000, 1004, 1008, 1010, each for 3 cycles; `done` at cycle 12 after start, `busy` low there, `fin` stays 1010.
- **Down sweep with overflow-safe clamp.**
  - `f_start=20`, `f_stop=5`, `f_step=8`, `dwell=1` → 20, 12, 5, then `done`.
  - `f_start=0xFFFFF0`, `f_stop=0xFFFFFF`, `f_step=0x20` → 0xFFFFF0, 0xFFFFFF with no wrap.
- **Triangle.** `f_start=0`, `f_stop=6`, `f_step=3`, `dwell=2`, mode 10 → 0, 3, 6, 3, 0, 3, …; each endpoint held 2 cycles; `done` pulses at each endpoint exit; `busy` stays 1.
- **Sawtooth repeat.** Same as the single up-sweep case but mode 01 → after 1010 is held 3 cycles, `fin=1000` in the same cycle as `done`; the pattern repeats.
- **Abort.**
  - Assert `stop` while `fin=1004` → next edge IDLE, `busy=0`, `fin=1004` holds, no `done`.
  - `start` and `stop` asserted together from IDLE → stays IDLE.
  - `rst_n` low mid-sweep → all outputs 0 asynchronously.
- **Degenerate inputs.**
  - `dwell=0` behaves as `dwell=1`.
  - `f_step=0` clamps to `f_stop` after one dwell.
  - `f_start == f_stop` → a single value held D cycles, then `done`.
  - Changing `f_stop` mid-sweep has no effect.
